pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width; legal values are powers of two, 2..64.
REQ-002 The block SHALL have parameter LPS, default 1, the number of mux layers per pipeline stage; legal values are 1..SHW.
REQ-003 The block SHALL derive SHW = clog2(WIDTH) and NSTG = ceil(SHW/LPS), neither overridable.
REQ-004 The block SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block accepts the request this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHW  shift amount
- in_op  in  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result
- out_data  out  WIDTH  result
- out_zero  out  1  out_data == 0
- out_illegal  out  1  in_op was 101..111

Function
REQ-006 A request SHALL transfer when in_valid && in_ready; a result SHALL transfer when out_valid && out_ready.
REQ-007 Results SHALL be exact modulo WIDTH:
- SLL and SRL zero-fill.
- SRA fills with in_data[WIDTH-1].
- ROL and ROR wrap bits around.
REQ-008 Layer k SHALL shift or rotate by 2^k when shamt bit k is set, for k = 0..SHW-1 in ascending order; shamt 0 SHALL return in_data unchanged for every mode.
REQ-009 Stage s SHALL contain layers s*LPS .. min((s+1)*LPS, SHW)-1 followed by a register holding: valid, data, remaining shamt bits, op, and the original MSB.
REQ-010 Latency SHALL be exactly NSTG cycles from the accepting edge to out_valid, with out_ready held high.
REQ-011 Throughput SHALL be one transfer per cycle when out_ready is held high.
REQ-012 Stage s SHALL load when its register is empty, or when stage s+1 loads in the same cycle (the last stage counts as loading when out_ready=1); otherwise it SHALL hold all contents.
REQ-013 in_ready SHALL equal the stage-0 load condition; the ready path is combinational from out_ready, with no skid buffer.
REQ-014 A full pipeline with out_ready=0 SHALL hold NSTG results with no loss or duplication; out_data SHALL be stable while out_valid && !out_ready.
REQ-015 Simultaneous accept and drain in a full pipeline SHALL keep occupancy constant.
REQ-016 For illegal op codes, out_data SHALL equal in_data unshifted and out_illegal=1; out_illegal SHALL be 0 for legal codes.
REQ-017 out_zero and out_illegal SHALL be valid only while out_valid=1 and SHALL be driven 0 otherwise.
REQ-018 Results SHALL leave in acceptance order.

Reset
REQ-019 While rst=1 at a clk edge, all stage valid bits SHALL be cleared and all data registers zeroed.
REQ-020 Outputs SHALL read out_valid=0, out_data=0, out_zero=0, out_illegal=0 from the first edge with rst=1.
REQ-021 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-022 Reset mid-operation SHALL discard all in-flight results, with no output transfer afterwards.

Structure
REQ-023 Package shifter_pkg SHALL hold the op code constants (OP_SLL..OP_ROR) and the clog2 function.
REQ-024 A sub-module shift_layer (parameters WIDTH and DIST; inputs data, en, op, msb; output data) SHALL implement one 2^k layer for all modes and be instantiated SHW times.

Verification
REQ-025 The bench SHALL cover these directed scenarios with WIDTH=32 and LPS=1 (NSTG=5) unless stated:
- SLL 0x0000_0001 by 31 -> 0x8000_0000 after exactly 5 cycles; SRL 0x8000_0000 by 31 -> 0x0000_0001.
- SRA 0x8000_0000 by 4 -> 0xF800_0000; SRA 0x7000_0000 by 4 -> 0x0700_0000; SLL 0xFFFF_FFFF by 0 -> 0xFFFF_FFFF.
- ROL 0x8000_0001 by 1 -> 0x0000_0003; ROR 0x0000_0001 by 4 -> 0x1000_0000; SRL 0x0000_000F by 4 -> 0x0 with out_zero=1.
- in_op=110, in_data=0x1234_5678 -> out_data 0x1234_5678 with out_illegal=1.
- 8 back-to-back requests with out_ready=0 -> in_ready drops after 5 accepts; releasing out_ready -> 8 in-order results, 1 per cycle, none lost or duplicated.
- rst pulsed with 3 requests in flight -> no output transfer afterwards; in_ready=1 in the first cycle after rst; repeat with WIDTH=8, LPS=3 (latency 1 cycle).

Randomized compare against a behavioural model of all modes SHALL complement these scenarios.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op codes and a
// constant-foldable clog2 used to size shift amounts and stage counts.
package shifter_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_layer.sv
// One barrel-shifter layer: shifts or rotates by the fixed distance DIST
// when en_i is set; illegal op codes pass the data through untouched.
module shift_layer
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic [2:0]       op_i,
  input  logic             msb_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        OP_SLL:  data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
        OP_SRL:  data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
        // msb_i is the operand's original sign, so fill stays correct across layers
        OP_SRA:  data_o = {{DIST{msb_i}}, data_i[WIDTH-1:DIST]};
        OP_ROL:  data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
        OP_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: SHW mux layers grouped LPS per stage, with a
// valid/ready handshake whose ready path ripples back from out_ready.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  LPS   = 1,
  localparam int SHW   = clog2(WIDTH),
  localparam int NSTG  = (SHW + LPS - 1) / LPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_illegal
);

  localparam int LAST = NSTG - 1;

  logic             valid_q [NSTG];
  logic [WIDTH-1:0] data_q  [NSTG];
  logic [SHW-1:0]   shamt_q [NSTG];
  logic [2:0]       op_q    [NSTG];
  logic             msb_q   [NSTG];
  logic [NSTG-1:0]  load;

  // A stage may load if it is empty or if everything downstream moves too.
  always_comb begin : ready_chain
    logic ld;
    ld         = !valid_q[LAST] || out_ready;
    load       = '0;
    load[LAST] = ld;
    for (int s = NSTG - 2; s >= 0; s--) begin
      ld      = !valid_q[s] || ld;
      load[s] = ld;
    end
  end

  assign in_ready = load[0] && !rst;

  genvar gi, gj;
  for (gi = 0; gi < NSTG; gi++) begin : g_stg
    localparam int LO = gi * LPS;
    localparam int HI = ((gi + 1) * LPS < SHW) ? (gi + 1) * LPS : SHW;
    localparam int NL = HI - LO;

    logic             v_in;
    logic             msb_in;
    logic [WIDTH-1:0] d_in;
    logic [SHW-1:0]   sh_in;
    logic [2:0]       op_in;
    logic [WIDTH-1:0] chain [NL+1];
    logic [WIDTH-1:0] data_d;

    if (gi == 0) begin : g_head
      assign v_in   = in_valid;
      assign d_in   = in_data;
      assign sh_in  = in_shamt;
      assign op_in  = in_op;
      assign msb_in = in_data[WIDTH-1];
    end else begin : g_link
      assign v_in   = valid_q[gi-1];
      assign d_in   = data_q[gi-1];
      assign sh_in  = shamt_q[gi-1];
      assign op_in  = op_q[gi-1];
      assign msb_in = msb_q[gi-1];
    end

    assign chain[0] = d_in;

    for (gj = 0; gj < NL; gj++) begin : g_lyr
      shift_layer #(
        .WIDTH (WIDTH),
        .DIST  (1 << (LO + gj))
      ) u_layer (
        .data_i (chain[gj]),
        .en_i   (sh_in[LO+gj]),
        .op_i   (op_in),
        .msb_i  (msb_in),
        .data_o (chain[gj+1])
      );
    end

    assign data_d = chain[NL];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[gi] <= 1'b0;
        data_q[gi]  <= '0;
        shamt_q[gi] <= '0;
        op_q[gi]    <= '0;
        msb_q[gi]   <= 1'b0;
      end else if (load[gi]) begin
        valid_q[gi] <= v_in;
        data_q[gi]  <= data_d;
        shamt_q[gi] <= sh_in;
        op_q[gi]    <= op_in;
        msb_q[gi]   <= msb_in;
      end
    end
  end

  assign out_valid   = valid_q[LAST];
  assign out_data    = valid_q[LAST] ? data_q[LAST] : '0;
  assign out_zero    = valid_q[LAST] && (data_q[LAST] == '0);
  assign out_illegal = valid_q[LAST] && (op_q[LAST] > OP_ROR);

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: a queue-based scoreboard for the 32-bit/LPS=1 build
// plus directed checks on an 8-bit/LPS=3 build.
module tb_pipe_shifter;
  import shifter_pkg::*;

  localparam int NSTG = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_illegal;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [2:0]  in_op;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, out_illegal8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_shamt8, in_op8;

  pipe_shifter #(.WIDTH(32), .LPS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_illegal(out_illegal)
  );

  pipe_shifter #(.WIDTH(8), .LPS(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_shamt(in_shamt8), .in_op(in_op8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_zero(out_zero8), .out_illegal(out_illegal8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference result from the mode definitions, using w-bit arithmetic in 64 bits.
  function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [63:0] d, input int sh);
    logic [63:0] mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x    = d & mask;
    case (op)
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      OP_SRA:  r = x[w-1] ? ((x >> sh) | ~(mask >> sh)) : (x >> sh);
      OP_ROL:  r = (x << sh) | (x >> (w - sh));
      OP_ROR:  r = (x >> sh) | (x << (w - sh));
      default: r = x;
    endcase
    return r & mask;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        il;
    int          t;
  } exp_t;

  exp_t q[$];
  int   ncyc  = 0;
  int   n_out = 0;
  bit   armed = 1'b0;

  // Scoreboard: each accepted request becomes visible NSTG edges later and
  // leaves in order; in_ready is set by occupancy vs. out_ready.
  always @(negedge clk) begin
    if (armed) begin
      bit          ev;
      exp_t        e;
      logic [63:0] r;
      ncyc++;
      ev = (q.size() > 0) && (ncyc - q[0].t >= NSTG);
      chk("out_valid", 64'(out_valid), 64'(ev));
      if (ev) begin
        chk("out_data", 64'(out_data), 64'(q[0].d));
        chk("out_zero", 64'(out_zero), 64'(q[0].d == 32'h0));
        chk("out_illegal", 64'(out_illegal), 64'(q[0].il));
      end else begin
        chk("idle_zero", 64'(out_zero), 64'd0);
        chk("idle_illegal", 64'(out_illegal), 64'd0);
      end
      chk("in_ready", 64'(in_ready), 64'(!rst && (out_ready || q.size() < NSTG)));
      if (rst) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() > 0) void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          r    = ref_model(32, in_op, 64'(in_data), int'(in_shamt));
          e.d  = r[31:0];
          e.il = (in_op > OP_ROR);
          e.t  = ncyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_out(input string name, input logic [31:0] d, input logic z, input logic il);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, "_data"}, 64'(out_data), 64'(d));
      chk({name, "_zero"}, 64'(out_zero), 64'(z));
      chk({name, "_illegal"}, 64'(out_illegal), 64'(il));
    end
    tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic send8(input string name, input logic [2:0] op, input logic [7:0] d, input logic [2:0] sh);
    logic [63:0] r;
    r         = ref_model(8, op, 64'(d), int'(sh));
    in_valid8 = 1'b1;
    in_op8    = op;
    in_data8  = d;
    in_shamt8 = sh;
    @(negedge clk);
    chk({name, "_in_ready"}, 64'(in_ready8), 64'd1);
    tick();
    in_valid8 = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid8), 64'd1);
    chk({name, "_data"}, 64'(out_data8), r);
    chk({name, "_zero"}, 64'(out_zero8), 64'(r == 64'd0));
    chk({name, "_illegal"}, 64'(out_illegal8), 64'(op > OP_ROR));
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_op8 = '0; out_ready8 = 1'b1;
    tick();
    tick();
    armed = 1'b1;
    @(negedge clk);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_valid8", 64'(out_valid8), 64'd0);
    chk("rst_in_ready8", 64'(in_ready8), 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // Literal pins on the reference model itself
    chk("pin_sll",  ref_model(32, OP_SLL, 64'h1, 31),          64'h8000_0000);
    chk("pin_srl",  ref_model(32, OP_SRL, 64'h8000_0000, 31),  64'h1);
    chk("pin_sra1", ref_model(32, OP_SRA, 64'h8000_0000, 4),   64'hF800_0000);
    chk("pin_sra0", ref_model(32, OP_SRA, 64'h7000_0000, 4),   64'h0700_0000);
    chk("pin_rol",  ref_model(32, OP_ROL, 64'h8000_0001, 1),   64'h3);
    chk("pin_ror",  ref_model(32, OP_ROR, 64'h1, 4),           64'h1000_0000);
    chk("pin_ill",  ref_model(32, 3'b110, 64'h1234_5678, 7),   64'h1234_5678);
    chk("pin_ror8", ref_model(8, OP_ROR, 64'h01, 3),           64'h20);

    // Exact latency
    send(OP_SLL, 32'h0000_0001, 5'd31);
    for (int i = 1; i < NSTG; i++) begin
      @(negedge clk);
      chk("lat_early", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'h8000_0000);
    tick();

    send(OP_SRL, 32'h8000_0000, 5'd31); expect_out("srl31", 32'h0000_0001, 1'b0, 1'b0);
    send(OP_SRA, 32'h8000_0000, 5'd4);  expect_out("sra_neg", 32'hF800_0000, 1'b0, 1'b0);
    send(OP_SRA, 32'h7000_0000, 5'd4);  expect_out("sra_pos", 32'h0700_0000, 1'b0, 1'b0);
    send(OP_SLL, 32'hFFFF_FFFF, 5'd0);  expect_out("sll0", 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(OP_ROL, 32'h8000_0001, 5'd1);  expect_out("rol1", 32'h0000_0003, 1'b0, 1'b0);
    send(OP_ROR, 32'h0000_0001, 5'd4);  expect_out("ror4", 32'h1000_0000, 1'b0, 1'b0);
    send(OP_SRL, 32'h0000_000F, 5'd4);  expect_out("srl_zero", 32'h0000_0000, 1'b1, 1'b0);
    send(3'b110, 32'h1234_5678, 5'd9);  expect_out("illegal", 32'h1234_5678, 1'b0, 1'b1);
    drain();

    // Backpressure: 8 requests against a stalled output
    begin
      int          acc;
      int          base;
      logic [31:0] pat [8];
      acc  = 0;
      base = n_out;
      for (int i = 0; i < 8; i++) pat[i] = $urandom;
      for (int c = 0; c < 21; c++) begin
        out_ready = (c >= 8);
        in_valid  = (acc < 8);
        in_op     = OP_ROL;
        in_data   = (acc < 8) ? pat[acc] : 32'h0;
        in_shamt  = 5'(acc * 3);
        @(negedge clk);
        if (c == 7) begin
          chk("bp_accepts", 64'(acc), 64'd5);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        if (c >= 8 && c < 16) chk("bp_stream", 64'(out_valid), 64'd1);
        if (in_valid && in_ready) acc++;
        tick();
      end
      in_valid = 1'b0;
      chk("bp_count", 64'(n_out - base), 64'd8);
    end
    drain();

    // Reset with three results in flight
    begin
      int base;
      out_ready = 1'b0;
      send(OP_SLL, 32'h1, 5'd1);
      send(OP_SRL, 32'hF0, 5'd2);
      send(OP_ROR, 32'h3, 5'd3);
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("mid_rst_data", 64'(out_data), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      base = n_out;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      tick();
      repeat (10) tick();
      chk("post_rst_no_out", 64'(n_out - base), 64'd0);
    end

    // Randomized traffic, all op codes
    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 3'($urandom_range(0, 7));
      in_data   = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      in_shamt  = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // 8-bit, three layers in one stage: single-cycle latency
    out_ready8 = 1'b1;
    send8("ror8", OP_ROR, 8'h01, 3'd3);
    send8("sra8", OP_SRA, 8'h90, 3'd7);
    for (int i = 0; i < 30; i++) begin
      send8("rnd8", 3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom));
    end

    begin
      int cnt;
      out_ready8 = 1'b0;
      in_valid8  = 1'b1;
      for (int i = 0; i < 3; i++) begin
        in_op8    = OP_SLL;
        in_data8  = 8'($urandom_range(1, 255));
        in_shamt8 = 3'd1;
        tick();
      end
      @(negedge clk);
      chk("r8_held", 64'(out_valid8), 64'd1);
      tick();
      rst       = 1'b1;
      in_valid8 = 1'b0;
      tick();
      @(negedge clk);
      chk("r8_rst_valid", 64'(out_valid8), 64'd0);
      chk("r8_rst_data", 64'(out_data8), 64'd0);
      chk("r8_rst_in_ready", 64'(in_ready8), 64'd0);
      tick();
      rst        = 1'b0;
      out_ready8 = 1'b1;
      @(negedge clk);
      chk("r8_post_in_ready", 64'(in_ready8), 64'd1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid8 && out_ready8) cnt++;
        tick();
        @(negedge clk);
      end
      chk("r8_no_out", 64'(cnt), 64'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
